// File: rtl/i2s_transmitter.sv
// I2S bus-master transmitter: divides mclk into sclk/lrclk and serialises
// stereo sample pairs MSB-first, one sclk after each lrclk edge.
module i2s_transmitter #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned MCLK_DIV   = 4
) (
    input  logic                  mclk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  mclk_out,
    output logic                  sclk_out,
    output logic                  lrclk_out,
    output logic                  sdout,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int unsigned DIV_W      = (MCLK_DIV > 2) ? $clog2(MCLK_DIV) : 1;
    localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(MCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_WIDTH);
    localparam logic [BIT_W-1:0] DATA_LEN = BIT_W'(DATA_WIDTH);

    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  sclk_q, sclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdout_q, sdout_d;
    logic                  fs_q, fs_d;
    logic                  ur_q, ur_d;
    logic                  hold_empty_q, hold_empty_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;

    logic                  fall;
    logic                  frame_wrap;
    logic                  accept;
    logic [BIT_W-1:0]      pos;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] chan;

    // The fall event is the mclk edge on which div_cnt wraps and sclk drops.
    assign fall       = (div_q == DIV_LAST);
    assign frame_wrap = fall && (bit_q == BIT_LAST);
    assign accept     = din_valid && hold_empty_q;

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            bit_q        <= BIT_LAST;
            sclk_q       <= 1'b0;
            lrclk_q      <= 1'b1;
            sdout_q      <= 1'b0;
            fs_q         <= 1'b0;
            ur_q         <= 1'b0;
            hold_empty_q <= 1'b1;
            hold_l_q     <= '0;
            hold_r_q     <= '0;
            left_q       <= '0;
            right_q      <= '0;
        end else begin
            div_q        <= div_d;
            bit_q        <= bit_d;
            sclk_q       <= sclk_d;
            lrclk_q      <= lrclk_d;
            sdout_q      <= sdout_d;
            fs_q         <= fs_d;
            ur_q         <= ur_d;
            hold_empty_q <= hold_empty_d;
            hold_l_q     <= hold_l_d;
            hold_r_q     <= hold_r_d;
            left_q       <= left_d;
            right_q      <= right_d;
        end
    end

    always_comb begin
        div_d        = fall ? '0 : div_q + DIV_W'(1);
        sclk_d       = (div_d >= DIV_HALF);
        bit_d        = bit_q;
        lrclk_d      = lrclk_q;
        sdout_d      = sdout_q;
        fs_d         = frame_wrap;
        ur_d         = frame_wrap && hold_empty_q;
        hold_empty_d = hold_empty_q;
        hold_l_d     = hold_l_q;
        hold_r_d     = hold_r_q;
        left_d       = left_q;
        right_d      = right_q;
        pos          = '0;
        idx          = '0;
        chan         = '0;

        // Slot position p=0 is the I2S delay bit; p>DATA_WIDTH is zero pad.
        if (fall) begin
            bit_d   = frame_wrap ? '0 : bit_q + BIT_W'(1);
            lrclk_d = (bit_d >= SLOT_LEN);
            pos     = lrclk_d ? bit_d - SLOT_LEN : bit_d;
            chan    = lrclk_d ? right_q : left_q;
            idx     = IDX_W'(DATA_LEN - pos);
            sdout_d = ((pos != '0) && (pos <= DATA_LEN)) ? chan[idx] : 1'b0;
        end

        // Both channels are captured together so a pair never splits across frames.
        if (frame_wrap) begin
            if (!hold_empty_q) begin
                left_d       = hold_l_q;
                right_d      = hold_r_q;
                hold_empty_d = 1'b1;
            end else begin
                left_d  = '0;
                right_d = '0;
            end
        end

        if (accept) begin
            hold_l_d     = left_data;
            hold_r_d     = right_data;
            hold_empty_d = 1'b0;
        end
    end

    assign din_ready   = hold_empty_q;
    assign mclk_out    = mclk;
    assign sclk_out    = sclk_q;
    assign lrclk_out   = lrclk_q;
    assign sdout       = sdout_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: a cycle model predicts frame timing,
// handshake and underrun; a serial monitor decodes sdout and checks each pair.
module tb_i2s_transmitter;

    localparam int unsigned DW    = 24;
    localparam int unsigned SW    = 32;
    localparam int unsigned MD    = 4;
    localparam int unsigned FRAME = 2 * SW * MD;
    localparam int unsigned SW2   = 25;
    localparam int unsigned MD2   = 8;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          mclk = 1'b0;
    logic          rst;
    logic [DW-1:0] left_data, right_data;
    logic          din_valid;
    logic          din_ready, mclk_out, sclk_out, lrclk_out, sdout, frame_start, underrun;

    logic          rst2;
    logic [DW-1:0] left2, right2;
    logic          valid2;
    logic          ready2, mclk_out2, sclk2, lrclk2, sdout2, fs2, ur2;

    int errors = 0;
    int checks = 0;

    always #5 mclk = ~mclk;

    i2s_transmitter #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .MCLK_DIV(MD)) u_dut (
        .mclk(mclk), .rst(rst), .left_data(left_data), .right_data(right_data),
        .din_valid(din_valid), .din_ready(din_ready), .mclk_out(mclk_out),
        .sclk_out(sclk_out), .lrclk_out(lrclk_out), .sdout(sdout),
        .frame_start(frame_start), .underrun(underrun)
    );

    i2s_transmitter #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW2), .MCLK_DIV(MD2)) u_dut2 (
        .mclk(mclk), .rst(rst2), .left_data(left2), .right_data(right2),
        .din_valid(valid2), .din_ready(ready2), .mclk_out(mclk_out2),
        .sclk_out(sclk2), .lrclk_out(lrclk2), .sdout(sdout2),
        .frame_start(fs2), .underrun(ur2)
    );

    // mclk edges since reset release
    int unsigned k;
    always @(posedge mclk or posedge rst) begin
        if (rst) k <= 0;
        else     k <= k + 1;
    end

    // Cycle model: frame timing, holding register, expected frame contents
    pair_t         exp_q[$];
    logic          m_full, pend, efs, eur;
    logic [DW-1:0] m_l, m_r, pend_l, pend_r;

    always @(negedge mclk) begin
        if (rst) begin
            exp_q.delete();
            m_full = 1'b0;
            pend   = 1'b0;
        end else begin
            efs = (k >= MD) && (((k - MD) % FRAME) == 0);
            eur = 1'b0;
            if (efs) begin
                if (m_full) begin
                    exp_q.push_back('{l: m_l, r: m_r});
                    m_full = 1'b0;
                end else begin
                    exp_q.push_back('{l: '0, r: '0});
                    eur = 1'b1;
                end
            end
            if (pend) begin
                m_full = 1'b1;
                m_l    = pend_l;
                m_r    = pend_r;
            end
            checks++;
            if (frame_start !== efs) begin
                errors++;
                $display("FAIL frame_start k=%0d: got %b expected %b", k, frame_start, efs);
            end
            checks++;
            if (underrun !== eur) begin
                errors++;
                $display("FAIL underrun k=%0d: got %b expected %b", k, underrun, eur);
            end
            checks++;
            if (din_ready !== !m_full) begin
                errors++;
                $display("FAIL din_ready k=%0d: got %b expected %b", k, din_ready, !m_full);
            end
            pend   = din_valid && din_ready;
            pend_l = left_data;
            pend_r = right_data;
        end
    end

    // Serial monitor: samples sdout on sclk rising edges
    logic          prev_sclk, prev_lr, synced;
    int            pos;
    logic [DW-1:0] word, rx_l;
    pair_t         expp;

    always @(negedge mclk) begin
        if (rst) begin
            prev_sclk = 1'b0;
            prev_lr   = 1'b1;
            synced    = 1'b0;
            pos       = 0;
        end else begin
            if (sclk_out && !prev_sclk) begin
                if (lrclk_out !== prev_lr) begin
                    if (synced) begin
                        checks++;
                        if (pos != int'(SW) - 1) begin
                            errors++;
                            $display("FAIL slot_length: got %0d expected %0d", pos + 1, SW);
                        end
                    end
                    pos = 0;
                    if (lrclk_out == 1'b0) synced = 1'b1;
                end else begin
                    pos++;
                end
                prev_lr = lrclk_out;
                if (synced) begin
                    if (pos >= 1 && pos <= int'(DW)) begin
                        word[int'(DW) - pos] = sdout;
                    end else begin
                        checks++;
                        if (sdout !== 1'b0) begin
                            errors++;
                            $display("FAIL pad_bit p=%0d: got %b expected 0", pos, sdout);
                        end
                    end
                    if (pos == int'(SW) - 1) begin
                        if (!lrclk_out) begin
                            rx_l = word;
                        end else begin
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL rx_pair: got L=%06h R=%06h expected no frame", rx_l, word);
                            end else begin
                                expp = exp_q.pop_front();
                                if (rx_l !== expp.l || word !== expp.r) begin
                                    errors++;
                                    $display("FAIL rx_pair: got L=%06h R=%06h expected L=%06h R=%06h",
                                             rx_l, word, expp.l, expp.r);
                                end
                            end
                        end
                    end
                end
            end
            prev_sclk = sclk_out;
        end
    end

    task automatic sync();
        @(posedge mclk);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge mclk);
        #2;
    endtask

    task automatic do_reset();
        sync();
        rst       = 1'b1;
        din_valid = 1'b0;
        sync();
        sync();
        rst = 1'b0;
    endtask

    // Presents a pair (leaves din_valid high) and returns the accepting edge number.
    task automatic write_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, output int unsigned acc_k);
        logic acc;
        logic done;
        done       = 1'b0;
        acc_k      = 0;
        din_valid  = 1'b1;
        left_data  = l;
        right_data = r;
        for (int i = 0; i < 1000; i++) begin
            @(negedge mclk);
            acc = din_ready;
            @(posedge mclk);
            #2;
            if (acc) begin
                acc_k = k;
                done  = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_timeout: got no accept expected accept within 1000 cycles");
        end
    endtask

    task automatic wait_fs(output int unsigned fk);
        logic found;
        found = 1'b0;
        fk    = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge mclk);
            if (frame_start) begin
                fk    = k;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL frame_start_timeout: got none expected one within 2000 cycles");
        end
    endtask

    task automatic test_reset();
        sync();
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        checks += 7;
        if (sclk_out !== 1'b0)    begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk_out); end
        if (lrclk_out !== 1'b1)   begin errors++; $display("FAIL rst_lrclk: got %b expected 1", lrclk_out); end
        if (sdout !== 1'b0)       begin errors++; $display("FAIL rst_sdout: got %b expected 0", sdout); end
        if (frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start: got %b expected 0", frame_start); end
        if (underrun !== 1'b0)    begin errors++; $display("FAIL rst_underrun: got %b expected 0", underrun); end
        if (din_ready !== 1'b1)   begin errors++; $display("FAIL rst_din_ready: got %b expected 1", din_ready); end
        if (mclk_out !== mclk)    begin errors++; $display("FAIL mclk_out: got %b expected %b", mclk_out, mclk); end
        sync();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int unsigned ak, fk;
        do_reset();
        write_pair(24'hA5F00F, 24'h123456, ak);
        din_valid = 1'b0;
        checks++;
        if (ak !== 1) begin errors++; $display("FAIL basic_accept_edge: got %0d expected 1", ak); end
        wait_fs(fk);
        checks++;
        if (fk !== MD) begin errors++; $display("FAIL first_frame_edge: got %0d expected %0d", fk, MD); end
        sync();
        wait_cycles(FRAME + 32);
    endtask

    task automatic test_underrun();
        int unsigned ak, fk, fk2;
        do_reset();
        wait_fs(fk);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_first: got %b expected 1", underrun); end
        sync();
        write_pair(24'h3C3C3C, 24'hC3C3C3, ak);
        din_valid = 1'b0;
        wait_fs(fk2);
        checks += 2;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_second: got %b expected 0", underrun); end
        if (fk2 - fk !== FRAME) begin errors++; $display("FAIL frame_period: got %0d expected %0d", fk2 - fk, FRAME); end
        sync();
        wait_cycles(FRAME + 32);
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals[8];
        int unsigned   ak[8];
        vals = '{24'h7FFFFF, 24'h800000, 24'h000001, 24'hFFFFFF,
                 24'h000000, 24'h555555, 24'hAAAAAA, 24'h123456};
        do_reset();
        for (int i = 0; i < 8; i++) write_pair(vals[i], ~vals[i], ak[i]);
        din_valid = 1'b0;
        checks += 2;
        if (ak[0] !== 1) begin errors++; $display("FAIL stream_accept0: got %0d expected 1", ak[0]); end
        if (ak[1] !== MD + 1) begin errors++; $display("FAIL stream_accept1: got %0d expected %0d", ak[1], MD + 1); end
        for (int i = 2; i < 8; i++) begin
            checks++;
            if (ak[i] - ak[i-1] !== FRAME) begin
                errors++;
                $display("FAIL stream_spacing[%0d]: got %0d expected %0d", i, ak[i] - ak[i-1], FRAME);
            end
        end
        wait_cycles(2 * FRAME);
    endtask

    task automatic test_reset_mid();
        int unsigned ak, fk;
        do_reset();
        write_pair(24'h111111, 24'h222222, ak);
        din_valid = 1'b0;
        write_pair(24'h333333, 24'h444444, ak);
        din_valid = 1'b0;
        for (int i = 0; i < 200 && k < MD + 10 * MD + 2; i++) sync();
        checks++;
        if (lrclk_out !== 1'b0) begin errors++; $display("FAIL mid_in_left_slot: got %b expected 0", lrclk_out); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (sclk_out !== 1'b0)  begin errors++; $display("FAIL mid_rst_sclk: got %b expected 0", sclk_out); end
        if (lrclk_out !== 1'b1) begin errors++; $display("FAIL mid_rst_lrclk: got %b expected 1", lrclk_out); end
        if (sdout !== 1'b0)     begin errors++; $display("FAIL mid_rst_sdout: got %b expected 0", sdout); end
        if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_din_ready: got %b expected 1", din_ready); end
        sync();
        sync();
        rst = 1'b0;
        write_pair(24'h5A5A5A, 24'hA5A5A5, ak);
        din_valid = 1'b0;
        checks++;
        if (ak !== 1) begin errors++; $display("FAIL mid_accept_edge: got %0d expected 1", ak); end
        wait_fs(fk);
        checks++;
        if (fk !== MD) begin errors++; $display("FAIL mid_restart_edge: got %0d expected %0d", fk, MD); end
        sync();
        wait_cycles(FRAME + 32);
    endtask

    task automatic test_alt_params();
        int            c, fs_first, fs_second, nr;
        int            rk[50];
        logic          lrb[50];
        logic          sdb[50];
        logic          prev, ur_first, lr_ok, pad_ok;
        logic [DW-1:0] wl, wr;
        c = 0; fs_first = 0; fs_second = 0; nr = 0; prev = 1'b0; ur_first = 1'b1;
        wl = '0; wr = '0;
        sync();
        rst2 = 1'b1;
        sync();
        sync();
        rst2   = 1'b0;
        valid2 = 1'b1;
        left2  = 24'hABCDEF;
        right2 = 24'h13579B;
        sync();
        valid2 = 1'b0;
        @(negedge mclk);
        c = 1;
        checks += 2;
        if (ready2 !== 1'b0)     begin errors++; $display("FAIL alt_ready_after_accept: got %b expected 0", ready2); end
        if (mclk_out2 !== mclk)  begin errors++; $display("FAIL alt_mclk_out: got %b expected %b", mclk_out2, mclk); end
        prev = sclk2;
        for (int i = 0; i < 1200; i++) begin
            @(negedge mclk);
            c++;
            if (fs2) begin
                if (fs_first == 0) begin
                    fs_first = c;
                    ur_first = ur2;
                end else begin
                    fs_second = c;
                    break;
                end
            end
            if (fs_first != 0 && sclk2 && !prev && nr < 50) begin
                rk[nr]  = c;
                lrb[nr] = lrclk2;
                sdb[nr] = sdout2;
                nr++;
            end
            prev = sclk2;
        end
        checks += 4;
        if (fs_first !== int'(MD2))   begin errors++; $display("FAIL alt_first_frame: got %0d expected %0d", fs_first, MD2); end
        if (ur_first !== 1'b0)        begin errors++; $display("FAIL alt_underrun: got %b expected 0", ur_first); end
        if (fs_second - fs_first !== int'(2 * SW2 * MD2))
            begin errors++; $display("FAIL alt_frame_len: got %0d expected %0d", fs_second - fs_first, 2 * SW2 * MD2); end
        if (nr !== 50)                begin errors++; $display("FAIL alt_bit_count: got %0d expected 50", nr); end
        if (nr == 50) begin
            lr_ok  = 1'b1;
            pad_ok = (sdb[0] === 1'b0) && (sdb[SW2] === 1'b0);
            for (int i = 0; i < 50; i++) if (lrb[i] !== (i >= int'(SW2))) lr_ok = 1'b0;
            for (int p = 1; p <= int'(DW); p++) begin
                wl[int'(DW) - p] = sdb[p];
                wr[int'(DW) - p] = sdb[int'(SW2) + p];
            end
            checks += 5;
            if (rk[1] - rk[0] !== int'(MD2)) begin errors++; $display("FAIL alt_sclk_period: got %0d expected %0d", rk[1] - rk[0], MD2); end
            if (!lr_ok)  begin errors++; $display("FAIL alt_lrclk_slots: got wrong slot pattern expected 25 low then 25 high"); end
            if (!pad_ok) begin errors++; $display("FAIL alt_delay_bits: got %b/%b expected 0/0", sdb[0], sdb[SW2]); end
            if (wl !== 24'hABCDEF) begin errors++; $display("FAIL alt_left: got %06h expected abcdef", wl); end
            if (wr !== 24'h13579B) begin errors++; $display("FAIL alt_right: got %06h expected 13579b", wr); end
        end
        sync();
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        left_data  = '0;
        right_data = '0;
        rst2       = 1'b1;
        valid2     = 1'b0;
        left2      = '0;
        right2     = '0;
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_alt_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2s_transmitter.md
Name: i2s_transmitter

Overview:
- I2S bus master transmitter: the output direction of the pedal audio path, feeding the DAC/codec.
- Divides mclk down to generate sclk and lrclk.
- Accepts stereo 24-bit samples through a valid/ready handshake and serialises them MSB-first in standard I2S framing: MSB one sclk after each lrclk edge, data driven on sclk falling edge.
- The same frame format is accepted by the team's i2s_receiver.

Parameters:
- DATA_WIDTH, 24, bits per audio sample.
- SLOT_WIDTH, 32, sclk periods per channel slot (>= DATA_WIDTH+1).
- MCLK_DIV, 4, mclk cycles per sclk period (even, >= 2).

Ports:
- mclk  in  1  system/master clock; all logic on posedge mclk.
- rst  in  1  asynchronous, active-high reset.
- left_data  in  DATA_WIDTH  left-channel sample, two's complement.
- right_data  in  DATA_WIDTH  right-channel sample.
- din_valid  in  1  sample pair valid.
- din_ready  out  1  holding register empty; pair accepted when din_valid && din_ready.
- mclk_out  out  1  mclk passthrough to the codec.
- sclk_out  out  1  bit clock, registered.
- lrclk_out  out  1  word select, registered; 0 = left, 1 = right.
- sdout  out  1  serial data, registered.
- frame_start  out  1  one-mclk pulse when a new frame (left slot) begins.
- underrun  out  1  one-mclk pulse when a frame starts with no sample held.

Behaviour:
Reset (asynchronous):
- div_cnt=0, bit_cnt=2*SLOT_WIDTH-1.
- sclk_out=0, lrclk_out=1, sdout=0, frame_start=0, underrun=0.
- Holding register empty, so din_ready=1. Shift registers cleared.

Divider:
- div_cnt counts 0..MCLK_DIV-1 and wraps.
- sclk_out registered, high while div_cnt >= MCLK_DIV/2. Duty cycle is 50%; sclk period is MCLK_DIV mclk cycles.

Fall event:
- Occurs on the mclk edge where div_cnt wraps MCLK_DIV-1 -> 0, i.e. the same edge on which sclk_out falls.
- On each fall event, bit_cnt increments mod 2*SLOT_WIDTH. lrclk_out and sdout update on this same edge only.

Slot position:
- p = bit_cnt mod SLOT_WIDTH.
- lrclk_out = (bit_cnt >= SLOT_WIDTH).
- sdout = channel sample bit [DATA_WIDTH-p] for p in 1..DATA_WIDTH; 0 for p=0 and for p > DATA_WIDTH (zero pad).
- MSB therefore appears one sclk after each lrclk transition and is stable across the following sclk rising edge.

Frame start (fall event where bit_cnt wraps to 0):
- If holding register full: left/right shift registers load from it, holding clears.
- Else: shift registers load zero, underrun pulses.
- frame_start pulses on this edge in both cases.
- The right sample is captured at frame start, not at the slot boundary, so both channels come from the same pair.

Handshake:
- din_ready = !hold_full.
- Accept (din_valid && din_ready) loads the holding register and sets full on the next edge.
- On a frame-start edge with holding full, din_ready stays low during that cycle. A write is accepted the following cycle at the earliest; no same-cycle refill.
- din_valid while full is ignored; data must be held by the source.

Other rules:
- First frame starts MCLK_DIV mclk cycles after reset release.
- Reset mid-frame: all outputs immediately return to reset values, and any held sample is discarded.
- Throughput: one pair per 2*SLOT_WIDTH*MCLK_DIV mclk cycles (256 at defaults).

Test Plan:
- Reset, write L=0xA5F00F, R=0x123456 before the first frame -> frame_start at mclk cycle 4; lrclk low for 32 sclk then high for 32. Sampling sdout on sclk rising edges gives bits 1..24 of the left slot = 0xA5F00F MSB-first and of the right slot = 0x123456; bit 0 and bits 25..31 of each slot = 0.
- Loop sdout/sclk_out/lrclk_out into i2s_receiver; stream 8 pairs (0x7FFFFF, 0x800000, 0x000001, ...) -> receiver outputs each value in order, and its dvalid pulses twice per frame.
- No write before the first frame -> underrun pulses with frame_start and sdout stays 0 for the whole frame. A write during that frame -> transmitted next frame with no underrun.
- Hold din_valid high continuously -> din_ready low from accept until frame start, exactly one pair accepted per 256 mclk cycles, no underrun.
- Assert rst at bit_cnt=10 of the left slot -> sclk_out=0, lrclk_out=1, sdout=0, din_ready=1 immediately. After release, a frame restarts 4 mclk later with the next written sample, and the aborted sample is not resent.
- MCLK_DIV=8, SLOT_WIDTH=25 -> sclk period 8 mclk, frame 400 mclk, sample bits occupy p=1..24 with no pad bits after the LSB.
